halt_report_engine: RTL and testbench

//  Synthesizable end-of-run reporter for the pipelined core.
//  - On a CPU halt it waits a drain period, then snapshots the exit status and N performance counters.
//  - It reads a signature region from RAM over a single-outstanding read handshake.
//  - It streams all of this as a framed byte report to the UART TX path.
//  - Replaces simulation-only finish/signature logic, so hardware runs produce the same report.

---
 rtl/risc_p_report_pkg.sv | 43 ++++
 rtl/report_byte_serializer.sv | 45 ++++
 rtl/halt_report_engine.sv | 207 ++++++++++++++++++++
 tb/tb_halt_report_engine.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_p_report_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | risc_p_report_pkg                                                          |
// | Shared state encoding, framing constants and helpers for the halt report. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package risc_p_report_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_DRAIN    = 4'd1,
    ST_HEADER   = 4'd2,
    ST_COUNTERS = 4'd3,
    ST_SIG_CNT  = 4'd4,
    ST_SIG_REQ  = 4'd5,
    ST_SIG_WAIT = 4'd6,
    ST_SIG_SEND = 4'd7,
    ST_TRAILER  = 4'd8,
    ST_DONE     = 4'd9
  } report_state_t;

  localparam logic [7:0] REPORT_MAGIC_HDR  = 8'hA5;
  localparam logic [7:0] REPORT_MAGIC_TRL  = 8'h5A;
  localparam int         REPORT_HDR_BYTES  = 6;
  localparam int         REPORT_CNT_BYTES  = 2;
  localparam int         REPORT_WORD_BYTES = 4;

  // Word count of [begin, end) after aligning both ends down, clamped to max_words.
  function automatic logic [31:0] sig_word_count(input logic [31:0] begin_addr,
                                                 input logic [31:0] end_addr,
                                                 input logic [31:0] max_words);
    logic [31:0] b_al;
    logic [31:0] e_al;
    logic [31:0] n;
    b_al = {begin_addr[31:2], 2'b00};
    e_al = {end_addr[31:2], 2'b00};
    n    = (e_al > b_al) ? ((e_al - b_al) >> 2) : 32'd0;
    if (n > max_words) n = max_words;
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/report_byte_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | report_byte_serializer                                                     |
// | Loads a word plus byte count and shifts it out LSB-first on a handshake.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module report_byte_serializer #(
  parameter int W   = 64,
  parameter int NBW = $clog2(W/8 + 1)
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  input  logic           i_load,
  input  logic [W-1:0]   i_word,
  input  logic [NBW-1:0] i_nbytes,
  input  logic           i_ready,
  output logic           o_valid,
  output logic [7:0]     o_data,
  output logic           o_last,
  output logic           o_fire
);

  logic [W-1:0]   r_shift;
  logic [NBW-1:0] r_left;

  assign o_valid = (r_left != '0);
  assign o_data  = o_valid ? r_shift[7:0] : 8'h00;
  assign o_last  = (r_left == NBW'(1));
  assign o_fire  = o_valid & i_ready;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_shift <= '0;
      r_left  <= '0;
    end else if (i_load) begin
      r_shift <= i_word;
      r_left  <= i_nbytes;
    end else if (o_fire) begin
      r_shift <= {8'h00, r_shift[W-1:8]};
      r_left  <= r_left - NBW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/halt_report_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | halt_report_engine                                                         |
// | After a drained CPU halt, streams status, counters and RAM signature.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module halt_report_engine
  import risc_p_report_pkg::*;
#(
  parameter int NUM_COUNTERS  = 4,
  parameter int COUNTER_WIDTH = 64,
  parameter int DRAIN_CYCLES  = 4,
  parameter int MAX_SIG_WORDS = 4096
) (
  input  logic                                  clk_i,
  input  logic                                  rst_n_i,
  input  logic                                  halted_i,
  input  logic                                  looping_i,
  input  logic [31:0]                           trap_mcause_i,
  input  logic [NUM_COUNTERS*COUNTER_WIDTH-1:0] counters_i,
  input  logic [31:0]                           sig_begin_i,
  input  logic [31:0]                           sig_end_i,
  output logic                                  mem_rd_req_o,
  output logic [31:0]                           mem_rd_addr_o,
  input  logic                                  mem_rd_ack_i,
  input  logic [31:0]                           mem_rd_data_i,
  output logic [7:0]                            tx_data_o,
  output logic                                  tx_valid_o,
  input  logic                                  tx_ready_i,
  output logic                                  done_o,
  output logic                                  exit_code_o
);

  localparam int SER_W = (COUNTER_WIDTH > 48) ? COUNTER_WIDTH : 48;
  localparam int NBW   = $clog2(SER_W/8 + 1);
  localparam int CIDXW = (NUM_COUNTERS > 1) ? $clog2(NUM_COUNTERS) : 1;
  localparam int IDXW  = $clog2(MAX_SIG_WORDS + 1);
  localparam int CTRW  = NUM_COUNTERS * COUNTER_WIDTH;

  report_state_t          r_state;
  report_state_t          w_state_nxt;
  logic [7:0]             r_drain_cnt;
  logic                   r_exit;
  logic [31:0]            r_mcause;
  logic [CTRW-1:0]        r_counters;
  logic [31:0]            r_sig_base;
  logic [IDXW-1:0]        r_nwords;
  logic [IDXW-1:0]        r_idx;
  logic [CIDXW-1:0]       r_cidx;
  logic [31:0]            r_word;

  logic                   w_ser_load;
  logic [SER_W-1:0]       w_ser_word;
  logic [NBW-1:0]         w_ser_nbytes;
  logic                   w_ser_valid;
  logic [7:0]             w_ser_data;
  logic                   w_ser_last;
  logic                   w_ser_fire;

  logic                   w_snapshot;
  logic                   w_byte_done;
  logic                   w_last_ctr;
  logic                   w_last_word;
  logic                   w_mem_req;
  logic                   w_ack;
  logic [31:0]            w_nwords32;
  logic [COUNTER_WIDTH-1:0] w_cur_ctr;

  assign w_snapshot  = (r_state == ST_DRAIN) && halted_i && (r_drain_cnt == 8'd0);
  assign w_byte_done = w_ser_fire & w_ser_last;
  assign w_last_ctr  = (r_cidx == CIDXW'(NUM_COUNTERS - 1));
  assign w_last_word = ((r_idx + IDXW'(1)) == r_nwords);
  assign w_mem_req   = (r_state == ST_SIG_REQ) || (r_state == ST_SIG_WAIT);
  assign w_ack       = w_mem_req & mem_rd_ack_i;
  assign w_nwords32  = 32'(r_nwords);
  assign w_cur_ctr   = r_counters[int'(r_cidx)*COUNTER_WIDTH +: COUNTER_WIDTH];

  report_byte_serializer #(
    .W   (SER_W),
    .NBW (NBW)
  ) u_ser (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .i_load   (w_ser_load),
    .i_word   (w_ser_word),
    .i_nbytes (w_ser_nbytes),
    .i_ready  (tx_ready_i),
    .o_valid  (w_ser_valid),
    .o_data   (w_ser_data),
    .o_last   (w_ser_last),
    .o_fire   (w_ser_fire)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Emitting states load the serializer whenever it is empty and leave on its last byte.
  always_comb begin
    w_state_nxt  = r_state;
    w_ser_load   = 1'b0;
    w_ser_word   = '0;
    w_ser_nbytes = '0;
    case (r_state)
      ST_IDLE: begin
        if (halted_i) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!halted_i)                 w_state_nxt = ST_IDLE;
        else if (r_drain_cnt == 8'd0)  w_state_nxt = ST_HEADER;
      end
      ST_HEADER: begin
        w_ser_load   = !w_ser_valid;
        w_ser_word   = SER_W'({r_mcause, 7'b0, r_exit, REPORT_MAGIC_HDR});
        w_ser_nbytes = NBW'(REPORT_HDR_BYTES);
        if (w_byte_done) w_state_nxt = ST_COUNTERS;
      end
      ST_COUNTERS: begin
        w_ser_load   = !w_ser_valid;
        w_ser_word   = SER_W'(w_cur_ctr);
        w_ser_nbytes = NBW'(COUNTER_WIDTH / 8);
        if (w_byte_done && w_last_ctr) w_state_nxt = ST_SIG_CNT;
      end
      ST_SIG_CNT: begin
        w_ser_load   = !w_ser_valid;
        w_ser_word   = SER_W'(w_nwords32[15:0]);
        w_ser_nbytes = NBW'(REPORT_CNT_BYTES);
        if (w_byte_done) w_state_nxt = (r_nwords == '0) ? ST_TRAILER : ST_SIG_REQ;
      end
      ST_SIG_REQ: begin
        w_state_nxt = mem_rd_ack_i ? ST_SIG_SEND : ST_SIG_WAIT;
      end
      ST_SIG_WAIT: begin
        if (mem_rd_ack_i) w_state_nxt = ST_SIG_SEND;
      end
      ST_SIG_SEND: begin
        w_ser_load   = !w_ser_valid;
        w_ser_word   = SER_W'(r_word);
        w_ser_nbytes = NBW'(REPORT_WORD_BYTES);
        if (w_byte_done) w_state_nxt = w_last_word ? ST_TRAILER : ST_SIG_REQ;
      end
      ST_TRAILER: begin
        w_ser_load   = !w_ser_valid;
        w_ser_word   = SER_W'(REPORT_MAGIC_TRL);
        w_ser_nbytes = NBW'(1);
        if (w_byte_done) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_state_nxt = ST_DONE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_drain_cnt <= 8'd0;
      r_exit      <= 1'b0;
      r_mcause    <= '0;
      r_counters  <= '0;
      r_sig_base  <= '0;
      r_nwords    <= '0;
      r_idx       <= '0;
      r_cidx      <= '0;
      r_word      <= '0;
    end else begin
      if ((r_state == ST_IDLE) && halted_i) begin
        r_drain_cnt <= 8'(DRAIN_CYCLES - 1);
      end else if ((r_state == ST_DRAIN) && (r_drain_cnt != 8'd0)) begin
        r_drain_cnt <= r_drain_cnt - 8'd1;
      end
      if (w_snapshot) begin
        r_exit     <= ~looping_i;
        r_mcause   <= trap_mcause_i;
        r_counters <= counters_i;
        r_sig_base <= {sig_begin_i[31:2], 2'b00};
        r_nwords   <= IDXW'(sig_word_count(sig_begin_i, sig_end_i, 32'(MAX_SIG_WORDS)));
        r_idx      <= '0;
        r_cidx     <= '0;
      end
      if ((r_state == ST_COUNTERS) && w_byte_done && !w_last_ctr) begin
        r_cidx <= r_cidx + CIDXW'(1);
      end
      if (w_ack) begin
        r_word <= mem_rd_data_i;
      end
      if ((r_state == ST_SIG_SEND) && w_byte_done) begin
        r_idx <= r_idx + IDXW'(1);
      end
    end
  end

  assign mem_rd_req_o  = w_mem_req;
  assign mem_rd_addr_o = w_mem_req ? (r_sig_base + (32'(r_idx) << 2)) : 32'd0;
  assign tx_data_o     = w_ser_data;
  assign tx_valid_o    = w_ser_valid;
  assign done_o        = (r_state == ST_DONE);
  assign exit_code_o   = r_exit;

endmodule
`default_nettype wire

// File: tb/tb_halt_report_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_halt_report_engine                                                      |
// | Directed and randomized report runs checked against a byte-stream model.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_halt_report_engine;

  localparam int NC   = 4;
  localparam int CW   = 64;
  localparam int DC   = 4;
  localparam int MAXW = 6;

  logic              clk_i;
  logic              rst_n_i;
  logic              halted_i;
  logic              looping_i;
  logic [31:0]       trap_mcause_i;
  logic [NC*CW-1:0]  counters_i;
  logic [31:0]       sig_begin_i;
  logic [31:0]       sig_end_i;
  logic              mem_rd_req_o;
  logic [31:0]       mem_rd_addr_o;
  logic              mem_rd_ack_i;
  logic [31:0]       mem_rd_data_i;
  logic [7:0]        tx_data_o;
  logic              tx_valid_o;
  logic              tx_ready_i;
  logic              done_o;
  logic              exit_code_o;

  halt_report_engine #(
    .NUM_COUNTERS  (NC),
    .COUNTER_WIDTH (CW),
    .DRAIN_CYCLES  (DC),
    .MAX_SIG_WORDS (MAXW)
  ) dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .halted_i      (halted_i),
    .looping_i     (looping_i),
    .trap_mcause_i (trap_mcause_i),
    .counters_i    (counters_i),
    .sig_begin_i   (sig_begin_i),
    .sig_end_i     (sig_end_i),
    .mem_rd_req_o  (mem_rd_req_o),
    .mem_rd_addr_o (mem_rd_addr_o),
    .mem_rd_ack_i  (mem_rd_ack_i),
    .mem_rd_data_i (mem_rd_data_i),
    .tx_data_o     (tx_data_o),
    .tx_valid_o    (tx_valid_o),
    .tx_ready_i    (tx_ready_i),
    .done_o        (done_o),
    .exit_code_o   (exit_code_o)
  );

  int          checks;
  int          errors;
  logic [7:0]  cap[$];
  logic [7:0]  exp_q[$];
  logic [31:0] exp_addr[$];
  logic [31:0] obs_addr[$];
  int          stall_bad;
  int          forbidden;
  int          valid_cycles;
  int          addr_unstable;
  int          ready_low_pct;
  int          ack_delay_max;
  int          spur_cnt;
  int          spur_seen;
  logic [31:0] ram [logic [31:0]];

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  function automatic logic [31:0] ram_rd(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  // TX sink: random backpressure, byte capture, stall-stability and forbidden-valid tracking.
  initial begin : sink
    logic       stall;
    logic [7:0] held;
    stall = 1'b0;
    held  = 8'h00;
    tx_ready_i = 1'b0;
    forever begin
      @(negedge clk_i);
      if (!rst_n_i) begin
        cap.delete();
        stall = 1'b0;
        stall_bad = 0;
        forbidden = 0;
        valid_cycles = 0;
        tx_ready_i = 1'b0;
      end else begin
        if (stall && (!tx_valid_o || (tx_data_o !== held))) stall_bad++;
        if (tx_valid_o && (mem_rd_req_o || done_o)) forbidden++;
        if (tx_valid_o) valid_cycles++;
        tx_ready_i = (int'($urandom_range(99, 0)) >= ready_low_pct);
        if (tx_valid_o && tx_ready_i) cap.push_back(tx_data_o);
        stall = tx_valid_o && !tx_ready_i;
        held  = tx_data_o;
      end
    end
  end

  // RAM responder: delayed single-cycle acks, logs every new request address.
  initial begin : responder
    bit          pending;
    int          dly;
    logic [31:0] cur;
    pending = 1'b0;
    dly = 0;
    cur = 32'd0;
    mem_rd_ack_i  = 1'b0;
    mem_rd_data_i = 32'd0;
    forever begin
      @(negedge clk_i);
      mem_rd_ack_i = 1'b0;
      if (!rst_n_i) begin
        pending = 1'b0;
        obs_addr.delete();
        addr_unstable = 0;
      end else if (mem_rd_req_o) begin
        if (!pending) begin
          pending = 1'b1;
          cur = mem_rd_addr_o;
          obs_addr.push_back(cur);
          dly = int'($urandom_range(ack_delay_max, 0));
        end else if (mem_rd_addr_o !== cur) begin
          addr_unstable++;
        end
        if (dly == 0) begin
          mem_rd_ack_i  = 1'b1;
          mem_rd_data_i = ram_rd(cur);
          pending = 1'b0;
        end else begin
          dly--;
        end
      end else if (spur_cnt != spur_seen) begin
        spur_seen = spur_cnt;
        mem_rd_ack_i  = 1'b1;
        mem_rd_data_i = 32'hDEAD_BEEF;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk_i);
    rst_n_i  = 1'b0;
    halted_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic build_expected(input bit lp, input logic [31:0] mc, input logic [63:0] ctr[NC],
                                input logic [31:0] b, input logic [31:0] e);
    logic [31:0] ba, ea, n, w;
    exp_q.delete();
    exp_addr.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(lp ? 8'h00 : 8'h01);
    for (int i = 0; i < 4; i++) exp_q.push_back(8'(mc >> (8 * i)));
    for (int k = 0; k < NC; k++)
      for (int i = 0; i < CW / 8; i++) exp_q.push_back(8'(ctr[k] >> (8 * i)));
    ba = b & ~32'd3;
    ea = e & ~32'd3;
    n  = (ea > ba) ? (ea - ba) / 4 : 32'd0;
    if (n > MAXW) n = MAXW;
    exp_q.push_back(n[7:0]);
    exp_q.push_back(n[15:8]);
    for (int i = 0; i < int'(n); i++) begin
      exp_addr.push_back(ba + 32'(4 * i));
      w = ram_rd(ba + 32'(4 * i));
      for (int j = 0; j < 4; j++) exp_q.push_back(8'(w >> (8 * j)));
    end
    exp_q.push_back(8'h5A);
  endtask

  task automatic drive_inputs(input bit lp, input logic [31:0] mc, input logic [63:0] ctr[NC],
                              input logic [31:0] b, input logic [31:0] e);
    looping_i = lp;
    trap_mcause_i = mc;
    for (int k = 0; k < NC; k++) counters_i[k*CW +: CW] = ctr[k];
    sig_begin_i = b;
    sig_end_i   = e;
  endtask

  task automatic run_report(input string name, input bit do_rst, input bit lp, input logic [31:0] mc,
                            input logic [63:0] ctr[NC], input logic [31:0] b, input logic [31:0] e,
                            input int rlow, input int dmax, input bit spur);
    bit started;
    int cyc;
    int n;
    if (do_rst) apply_reset();
    ready_low_pct = rlow;
    ack_delay_max = dmax;
    drive_inputs(lp, mc, ctr, b, e);
    build_expected(lp, mc, ctr, b, e);
    halted_i = 1'b1;
    started = 1'b0;
    cyc = 0;
    while (!done_o && cyc < 4000) begin
      @(negedge clk_i);
      cyc++;
      if (tx_valid_o && !started) begin
        started = 1'b1;
        if (spur) spur_cnt++;
        looping_i = ~lp;
        trap_mcause_i = $urandom;
        for (int k = 0; k < NC * CW / 32; k++) counters_i[k*32 +: 32] = $urandom;
        sig_begin_i = $urandom;
        sig_end_i   = $urandom;
      end
      if (started) halted_i = 1'($urandom_range(1, 0));
    end
    check({name, "_done"}, done_o, 1);
    check({name, "_exit"}, exit_code_o, lp ? 0 : 1);
    check({name, "_len"}, cap.size(), exp_q.size());
    n = (cap.size() < exp_q.size()) ? cap.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_byte%0d", name, i), cap[i], exp_q[i]);
    check({name, "_nreq"}, obs_addr.size(), exp_addr.size());
    n = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_addr%0d", name, i), obs_addr[i], exp_addr[i]);
    check({name, "_stall_stable"}, stall_bad, 0);
    check({name, "_valid_forbidden"}, forbidden, 0);
    check({name, "_addr_held"}, addr_unstable, 0);
    check({name, "_valid_in_done"}, tx_valid_o, 0);
    halted_i = 1'b0;
  endtask

  initial begin : main
    logic [63:0] c1[NC];
    logic [63:0] cr[NC];
    int          cyc;
    logic [31:0] rb;
    checks = 0;
    errors = 0;
    ready_low_pct = 0;
    ack_delay_max = 0;
    spur_cnt = 0;
    rst_n_i = 1'b0;
    halted_i = 1'b0;
    looping_i = 1'b0;
    trap_mcause_i = 32'd0;
    counters_i = '0;
    sig_begin_i = 32'd0;
    sig_end_i = 32'd0;
    ram[32'h1000] = 32'h1122_3344;
    ram[32'h1004] = 32'h5566_7788;
    c1 = '{64'd5, 64'd7, 64'd0, 64'd0};

    repeat (3) @(negedge clk_i);
    check("rst_tx_valid", tx_valid_o, 0);
    check("rst_tx_data", tx_data_o, 0);
    check("rst_req", mem_rd_req_o, 0);
    check("rst_addr", mem_rd_addr_o, 0);
    check("rst_done", done_o, 0);
    check("rst_exit", exit_code_o, 0);
    rst_n_i = 1'b1;

    run_report("t1", 1'b1, 1'b1, 32'd0, c1, 32'h1000, 32'h1008, 0, 0, 1'b0);

    apply_reset();
    halted_i = 1'b1;
    repeat (DC - 1) @(negedge clk_i);
    halted_i = 1'b0;
    repeat (20) @(negedge clk_i);
    check("t2_no_valid", valid_cycles, 0);
    check("t2_no_req", obs_addr.size(), 0);
    check("t2_not_done", done_o, 0);
    run_report("t2", 1'b0, 1'b1, 32'h0000_0100, c1, 32'h1000, 32'h1008, 0, 2, 1'b0);

    run_report("t3", 1'b1, 1'b0, 32'h0000_0008, c1, 32'h1008, 32'h1000, 0, 0, 1'b0);
    run_report("t4", 1'b1, 1'b1, 32'd0, c1, 32'h1000, 32'h1008, 30, 0, 1'b0);
    run_report("t5", 1'b1, 1'b1, 32'd0, c1, 32'h1000, 32'h1008, 0, 7, 1'b1);
    run_report("clamp", 1'b1, 1'b0, 32'h0000_0004, c1, 32'h2002, 32'h2041, 20, 3, 1'b0);
    run_report("exact_max", 1'b1, 1'b1, 32'd0, c1, 32'h2000, 32'h2018, 0, 1, 1'b0);

    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < NC; k++) cr[k] = {$urandom, $urandom};
      rb = 32'h3000 + 32'($urandom_range(7, 0));
      run_report($sformatf("rnd%0d", r), 1'b1, 1'($urandom_range(1, 0)), $urandom, cr,
                 rb, rb + 32'($urandom_range(30, 0)), 30, 7, 1'b1);
    end

    apply_reset();
    ready_low_pct = 30;
    ack_delay_max = 3;
    drive_inputs(1'b0, 32'h0000_0002, c1, 32'h1000, 32'h1010);
    halted_i = 1'b1;
    cyc = 0;
    while (cap.size() < 42 && cyc < 4000) begin
      @(negedge clk_i);
      cyc++;
    end
    check("t6_reached_sig", (cap.size() >= 42) ? 1 : 0, 1);
    check("t6_exit_before", exit_code_o, 1);
    rst_n_i = 1'b0;
    #1;
    check("t6_tx_valid", tx_valid_o, 0);
    check("t6_tx_data", tx_data_o, 0);
    check("t6_req", mem_rd_req_o, 0);
    check("t6_addr", mem_rd_addr_o, 0);
    check("t6_done", done_o, 0);
    check("t6_exit", exit_code_o, 0);
    halted_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("t6_hold_valid", tx_valid_o, 0);
    rst_n_i = 1'b1;
    @(negedge clk_i);
    run_report("t6_fresh", 1'b0, 1'b1, 32'd0, c1, 32'h1000, 32'h1008, 30, 3, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
